// File: rtl/multi_channel_packetizer.sv
// multi_channel_packetizer
//
// Snapshots NUM_INPUTS channel words on each capture strobe into a
// DEPTH-entry snapshot FIFO and streams every snapshot out as one
// AXI-Stream packet. The packet is a header word followed by the
// enabled channels in ascending index order.
//
// Header layout: [31:24] ID, [23:16] sequence number, [15:0] number of
// enabled channels. Bits above 31 are zero. When ENDIAN_SWAP is set,
// the payload words are byte-reversed as they are written into the
// FIFO; the header is never swapped. WIDTH is assumed to be a multiple
// of 8 for the byte reversal.
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   capture      snapshot strobe, sampled every cycle
//   d, ch_en     channel words and per-capture channel enable mask
//   tready       downstream ready
//   tdata, tvalid, tlast  AXI-Stream master outputs (registered)
//   busy         FIFO non-empty or packet in flight (registered)
//   overflow     one-cycle pulse after a capture dropped on a full FIFO
//   drop_count   saturating count of dropped captures
module multi_channel_packetizer #(
    parameter int unsigned NUM_INPUTS  = 16,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter logic [7:0]  ID          = 8'h00,
    parameter bit          ENDIAN_SWAP = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              capture,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]  d,
    input  logic [NUM_INPUTS-1:0]             ch_en,
    input  logic                              tready,
    output logic [WIDTH-1:0]                  tdata,
    output logic                              tvalid,
    output logic                              tlast,
    output logic                              busy,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         ONE_CNT  = CW'(1);
    localparam logic [AW-1:0]         LAST_PTR = AW'(DEPTH - 1);
    localparam logic [NUM_INPUTS-1:0] BIT0     = NUM_INPUTS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] byte_swap(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = w;
        for (int b = 0; b < int'(WIDTH / 8); b++) begin
            r[8*b +: 8] = w[int'(WIDTH) - 8 - 8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] popcount(input logic [NUM_INPUTS-1:0] m);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            c = c + 16'(m[i]);
        end
        return c;
    endfunction

    // Lowest set bit of the mask; zero when the mask is empty.
    function automatic logic [IW-1:0] first_set(input logic [NUM_INPUTS-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] make_header(input logic [7:0]  s,
                                                     input logic [15:0] l);
        logic [WIDTH-1:0] h;
        h        = '0;
        h[31:0]  = {ID, s, l};
        return h;
    endfunction

    // ------------------------------------------------------------------
    // Snapshot FIFO storage (data only, not reset)
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0][WIDTH-1:0] data_mem [DEPTH];
    logic [NUM_INPUTS-1:0]            mask_mem [DEPTH];
    logic [7:0]                       seq_mem  [DEPTH];
    logic [15:0]                      len_mem  [DEPTH];

    logic [NUM_INPUTS-1:0][WIDTH-1:0] d_store;

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [AW-1:0]          wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]          count_q,      count_d;
    logic [7:0]             seq_q,        seq_d;
    logic [WIDTH-1:0]       tdata_q,      tdata_d;
    logic                   tvalid_q,     tvalid_d;
    logic                   tlast_q,      tlast_d;
    logic [NUM_INPUTS-1:0]  rem_mask_q,   rem_mask_d;
    logic [IW-1:0]          nxt_idx_q,    nxt_idx_d;
    logic                   busy_q,       busy_d;
    logic                   overflow_q,   overflow_d;
    logic [15:0]            drop_count_q, drop_count_d;

    logic                   handshake;
    logic                   pop;
    logic                   full;
    logic                   accept;
    logic                   drop;
    logic [AW-1:0]          rd_ptr_nxt;
    logic                   load_hdr;
    logic [AW-1:0]          hdr_ptr;
    logic [NUM_INPUTS-1:0]  rem_after;

    always_comb begin
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            d_store[i] = ENDIAN_SWAP ? byte_swap(d[i]) : d[i];
        end
    end

    // A full FIFO that is popped this cycle still has room for the capture.
    assign handshake  = tvalid_q & tready;
    assign pop        = handshake & tlast_q;
    assign full       = (count_q == FULL_CNT);
    assign accept     = capture & (~full | pop);
    assign drop       = capture & full & ~pop;
    assign rd_ptr_nxt = ptr_inc(rd_ptr_q);

    // The word after the current one is already known through nxt_idx_q,
    // so only one priority encode of the shrinking mask sits in each cycle.
    assign rem_after  = rem_mask_q & ~(BIT0 << nxt_idx_q);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_nxt : rd_ptr_q;
        count_d      = count_q + CW'(accept) - CW'(pop);
        seq_d        = capture ? seq_q + 8'd1 : seq_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        rem_mask_d   = rem_mask_q;
        nxt_idx_d    = nxt_idx_q;
        overflow_d   = drop;
        drop_count_d = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1
                                                            : drop_count_q;
        load_hdr     = 1'b0;
        hdr_ptr      = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    load_hdr = 1'b1;
                    hdr_ptr  = rd_ptr_q;
                end
            end
            S_HDR, S_DATA: begin
                if (handshake) begin
                    if (tlast_q) begin
                        // Packet complete: chain straight into the next header
                        // when another snapshot is already stored.
                        if (count_q > ONE_CNT) begin
                            load_hdr = 1'b1;
                            hdr_ptr  = rd_ptr_nxt;
                        end else begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        state_d    = S_DATA;
                        tdata_d    = data_mem[rd_ptr_q][nxt_idx_q];
                        tlast_d    = (rem_after == '0);
                        rem_mask_d = rem_after;
                        nxt_idx_d  = first_set(rem_after);
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        if (load_hdr) begin
            state_d    = S_HDR;
            tdata_d    = make_header(seq_mem[hdr_ptr], len_mem[hdr_ptr]);
            tvalid_d   = 1'b1;
            tlast_d    = (len_mem[hdr_ptr] == 16'd0);
            rem_mask_d = mask_mem[hdr_ptr];
            nxt_idx_d  = first_set(mask_mem[hdr_ptr]);
        end

        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // FIFO write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr_q] <= d_store;
            mask_mem[wr_ptr_q] <= ch_en;
            seq_mem[wr_ptr_q]  <= seq_q;
            len_mem[wr_ptr_q]  <= popcount(ch_en);
        end
    end

    // ------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            rem_mask_q   <= '0;
            nxt_idx_q    <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            rem_mask_q   <= rem_mask_d;
            nxt_idx_q    <= nxt_idx_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tdata      = tdata_q;
    assign tvalid     = tvalid_q;
    assign tlast      = tlast_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/multi_channel_packetizer.md
# multi_channel_packetizer

Parametrised successor to the single-shot packetizer: snapshots NUM_INPUTS channel words on each `capture` strobe into a DEPTH-entry snapshot FIFO. Each snapshot is emitted as one AXI-Stream packet consisting of a header word followed by the enabled channels in ascending index order. It adds a per-capture channel mask, an 8-bit sequence number, a capture-overflow counter and back-to-back packet streaming. It sits between ADC/accumulator result registers and the DMA/stream merger.

## Interface
- NUM_INPUTS, 16: channel count, 1..255.
- WIDTH, 32: word width, ≥32.
- DEPTH, 4: snapshot FIFO entries, power of 2, ≥1.
- ID, 0: 8-bit stream ID placed in the header.
- ENDIAN_SWAP, 0: when 1, data words are byte-reversed; the header is never swapped.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- capture  in  1  snapshot strobe, level-sampled every cycle.
- d  in  [NUM_INPUTS-1:0][WIDTH-1:0]  channel data.
- ch_en  in  NUM_INPUTS  channel enable mask, sampled together with `d`.
- tready  in  1  AXI-S ready.
- tdata  out  WIDTH  AXI-S data.
- tvalid  out  1  AXI-S valid.
- tlast  out  1  AXI-S last.
- busy  out  1  high when the FIFO is non-empty or a packet is in flight.
- overflow  out  1  one-cycle pulse on a dropped capture.
- drop_count  out  16  dropped-capture count, saturates at 0xFFFF.

## Operation
- Capture accepted when `capture`=1 and FIFO not full. The entry stores `d` (swapped if ENDIAN_SWAP), `ch_en`, seq, and len = popcount(ch_en).
- Capture while FIFO full: entry dropped, `overflow` pulses, `drop_count`+1 (saturating).
- seq: 8-bit counter, reset 0. Increments on every capture, accepted or dropped, wrapping 255→0. Gaps in the sequence therefore reveal drops.
- Header word: bits[31:24]=ID[7:0], [23:16]=seq, [15:0]=len. Bits above 31 are zero.
- Payload: d[i] for each i with ch_en[i]=1, ascending i. Disabled channels are skipped with no idle cycle.
- len=0: the packet is the header only, with tlast=1 on the header.
- tlast is asserted on the final payload word only.
- Output FSM:
  - IDLE→HDR when the FIFO is non-empty.
  - HDR→DATA on handshake if len>0, otherwise →IDLE/HDR.
  - DATA→DATA per handshake; on the last word →HDR if another entry is pending, otherwise →IDLE.
  - The FIFO entry is popped on the tlast handshake.
- The FIFO may be written and popped in the same cycle; a full FIFO being popped that cycle still accepts the capture.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, overflow=0, drop_count=0, seq=0, FIFO empty, FSM=IDLE.
- Reset mid-packet: all of the above apply at the next edge; the partial packet is abandoned.
- Latency: capture sampled at edge N with the FIFO empty and the FSM in IDLE → header valid in the cycle after edge N+1 (2 clocks).
- Back-to-back: the next header is valid in the cycle immediately after the tlast handshake, with no bubble.
- Throughput: one word per cycle while tready=1.
- While tvalid=1 and tready=0: tdata and tlast hold stable, and tvalid is never withdrawn.
- Channel skipping uses a priority-encode of the remaining mask. The encoder must meet timing at NUM_INPUTS=64 (register the next index one word ahead).
- overflow is registered: it is high in the cycle after the dropped-capture edge.
- busy is registered and is low only when the FIFO is empty and the FSM is in IDLE.

## Test plan
- NUM_INPUTS=4, ch_en=4'hF, d={4,3,2,1}, ID=0xA5, tready=1, one capture → words 0xA5000004,1,2,3,4. tlast on word 4. Header visible 2 clocks after capture.
- Same config with ch_en=4'b1010 and ENDIAN_SWAP=1, d[1]=0x11223344, d[3]=0xAABBCCDD → header 0xA5000002, then 0x44332211, then 0xDDCCBBAA with tlast. Repeat with ch_en=0 → single word 0xA5010000 with tlast; seq=1.
- tready toggled randomly across 3 queued captures → tdata/tlast stable during stalls. Packets are contiguous, with seq 0,1,2.
- DEPTH=2, tready=0, 4 consecutive captures → two overflow pulses, drop_count=2. After tready=1, the emitted headers carry seq 0 and 1; the next capture carries seq 4.
- 256 captures → seq wraps 0xFF→0x00. drop_count is forced past 0xFFFF and holds at 0xFFFF.
- rst_n=0 during the DATA state → next cycle tvalid=0, busy=0. The first post-reset capture emits seq 0.
